// File: rtl/fighter_pkg.sv
// Shared fighter definitions: phase and attack-type encodings, frame-field
// packing helpers and default reach constants used by the attack/health blocks.
package fighter_pkg;

    typedef enum logic [1:0] {
        PH_IDLE     = 2'b00,
        PH_STARTUP  = 2'b01,
        PH_ACTIVE   = 2'b10,
        PH_RECOVERY = 2'b11
    } phase_t;

    // Numeric order doubles as button priority (heavy > medium > light)
    typedef enum logic [1:0] {
        ATK_NONE   = 2'b00,
        ATK_LIGHT  = 2'b01,
        ATK_MEDIUM = 2'b10,
        ATK_HEAVY  = 2'b11
    } atk_t;

    localparam logic [11:0] DEFAULT_LIGHT_FRAMES  = 12'h224;
    localparam logic [11:0] DEFAULT_MEDIUM_FRAMES = 12'h438;
    localparam logic [11:0] DEFAULT_HEAVY_FRAMES  = 12'h84E;

    localparam int DEFAULT_LIGHT_REACH  = 40;
    localparam int DEFAULT_MEDIUM_REACH = 56;
    localparam int DEFAULT_HEAVY_REACH  = 72;

    typedef struct packed {
        phase_t     phase;
        logic [3:0] count;
    } phase_load_t;

    function automatic logic [3:0] frame_field(input logic [11:0] frames, input phase_t ph);
        case (ph)
            PH_STARTUP:  return frames[11:8];
            PH_ACTIVE:   return frames[7:4];
            PH_RECOVERY: return frames[3:0];
            default:     return 4'd0;
        endcase
    endfunction

    // First phase at or after 'from' with a non-zero length; zero-length fields are skipped
    function automatic phase_load_t enter_phase(input logic [11:0] frames, input phase_t from);
        phase_load_t r;
        r.phase = PH_IDLE;
        r.count = 4'd0;
        if (from == PH_STARTUP && frame_field(frames, PH_STARTUP) != 4'd0) begin
            r.phase = PH_STARTUP;
            r.count = frame_field(frames, PH_STARTUP);
        end else if ((from == PH_STARTUP || from == PH_ACTIVE) &&
                     frame_field(frames, PH_ACTIVE) != 4'd0) begin
            r.phase = PH_ACTIVE;
            r.count = frame_field(frames, PH_ACTIVE);
        end else if (from != PH_IDLE && frame_field(frames, PH_RECOVERY) != 4'd0) begin
            r.phase = PH_RECOVERY;
            r.count = frame_field(frames, PH_RECOVERY);
        end
        return r;
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_STARTUP: return PH_ACTIVE;
            PH_ACTIVE:  return PH_RECOVERY;
            default:    return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/attack_range_check.sv
// Combinational reach comparator: is the opponent in front of us and within
// the current attack's reach? Differences are 11-bit so they never wrap.
module attack_range_check
    import fighter_pkg::*;
#(
    parameter int LIGHT_REACH  = DEFAULT_LIGHT_REACH,
    parameter int MEDIUM_REACH = DEFAULT_MEDIUM_REACH,
    parameter int HEAVY_REACH  = DEFAULT_HEAVY_REACH
) (
    input  logic [9:0] pos_self,
    input  logic [9:0] pos_opp,
    input  logic       facing_right,
    input  atk_t       atk_type,
    output logic       in_range
);

    logic [10:0] reach;
    logic [10:0] diff_fwd;
    logic [10:0] diff_back;

    assign diff_fwd  = {1'b0, pos_opp} - {1'b0, pos_self};
    assign diff_back = {1'b0, pos_self} - {1'b0, pos_opp};

    always_comb begin
        reach    = 11'd0;
        in_range = 1'b0;
        case (atk_type)
            ATK_LIGHT:  reach = 11'(LIGHT_REACH);
            ATK_MEDIUM: reach = 11'(MEDIUM_REACH);
            ATK_HEAVY:  reach = 11'(HEAVY_REACH);
            default:    reach = 11'd0;
        endcase
        if (atk_type != ATK_NONE) begin
            if (facing_right)
                in_range = (pos_opp >= pos_self) && (diff_fwd <= reach);
            else
                in_range = (pos_self >= pos_opp) && (diff_back <= reach);
        end
    end

endmodule

// File: rtl/attack_sequencer.sv
// Per-player attack FSM: button edges -> startup/active/recovery on frame ticks,
// one registered hit event per attack. Optional recovery buffer: ATTACK_SEQ_BUFFER_EN.
module attack_sequencer
    import fighter_pkg::*;
#(
    parameter logic [11:0] LIGHT_FRAMES  = DEFAULT_LIGHT_FRAMES,
    parameter logic [11:0] MEDIUM_FRAMES = DEFAULT_MEDIUM_FRAMES,
    parameter logic [11:0] HEAVY_FRAMES  = DEFAULT_HEAVY_FRAMES,
    parameter int          LIGHT_REACH   = DEFAULT_LIGHT_REACH,
    parameter int          MEDIUM_REACH  = DEFAULT_MEDIUM_REACH,
    parameter int          HEAVY_REACH   = DEFAULT_HEAVY_REACH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_light,
    input  logic       btn_medium,
    input  logic       btn_heavy,
    input  logic       stunned,
    input  logic       facing_right,
    input  logic [9:0] pos_self,
    input  logic [9:0] pos_opp,
    output logic [1:0] phase,
    output logic [1:0] atk_type,
    output logic [1:0] hit_type,
    output logic       hit_pulse,
    output logic       hit_in_range,
    output logic       busy
);

    phase_t      phase_q;
    atk_t        atk_q;
    logic [3:0]  count_q;
    logic        hit_done;
    logic [2:0]  btn_prev;
    logic [2:0]  btn_now;
    logic [2:0]  btn_rise;
    atk_t        edge_type;
    atk_t        pend_type;
    atk_t        launch_type;
    logic        launch_en;
    logic        phase_end;
    logic        in_range;
    phase_load_t launch_load;
    phase_load_t adv_load;

`ifdef ATTACK_SEQ_BUFFER_EN
    atk_t        buf_q;
`endif

    function automatic logic [11:0] frames_of(input atk_t t);
        case (t)
            ATK_LIGHT:  return LIGHT_FRAMES;
            ATK_MEDIUM: return MEDIUM_FRAMES;
            ATK_HEAVY:  return HEAVY_FRAMES;
            default:    return 12'h000;
        endcase
    endfunction

    attack_range_check #(
        .LIGHT_REACH (LIGHT_REACH),
        .MEDIUM_REACH(MEDIUM_REACH),
        .HEAVY_REACH (HEAVY_REACH)
    ) u_range (
        .pos_self    (pos_self),
        .pos_opp     (pos_opp),
        .facing_right(facing_right),
        .atk_type    (atk_q),
        .in_range    (in_range)
    );

    assign btn_now  = {btn_heavy, btn_medium, btn_light};
    assign btn_rise = btn_now & ~btn_prev;

    // A press held in the buffer or arriving on the last recovery tick relaunches directly
    always_comb begin
        edge_type = ATK_NONE;
        if (btn_rise[2])      edge_type = ATK_HEAVY;
        else if (btn_rise[1]) edge_type = ATK_MEDIUM;
        else if (btn_rise[0]) edge_type = ATK_LIGHT;
`ifdef ATTACK_SEQ_BUFFER_EN
        pend_type = (edge_type > buf_q) ? edge_type : buf_q;
`else
        pend_type = ATK_NONE;
`endif
        phase_end   = (phase_q != PH_IDLE) && frame_tick && (count_q <= 4'd1);
        launch_type = (phase_q == PH_IDLE) ? edge_type : pend_type;
        launch_en   = ((phase_q == PH_IDLE) && (edge_type != ATK_NONE)) ||
                      ((phase_q == PH_RECOVERY) && phase_end && (pend_type != ATK_NONE));
        launch_load = enter_phase(frames_of(launch_type), PH_STARTUP);
        adv_load    = enter_phase(frames_of(atk_q), next_phase(phase_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev     <= 3'b000;
            phase_q      <= PH_IDLE;
            atk_q        <= ATK_NONE;
            count_q      <= 4'd0;
            hit_done     <= 1'b0;
            hit_pulse    <= 1'b0;
            hit_in_range <= 1'b0;
            hit_type     <= 2'b00;
`ifdef ATTACK_SEQ_BUFFER_EN
            buf_q        <= ATK_NONE;
`endif
        end else begin
            btn_prev     <= btn_now;
            hit_pulse    <= 1'b0;
            hit_in_range <= 1'b0;
            hit_type     <= 2'b00;
            if (stunned) begin
                phase_q  <= PH_IDLE;
                atk_q    <= ATK_NONE;
                count_q  <= 4'd0;
                hit_done <= 1'b0;
`ifdef ATTACK_SEQ_BUFFER_EN
                buf_q    <= ATK_NONE;
`endif
            end else begin
                if (phase_q == PH_ACTIVE && in_range && !hit_done) begin
                    hit_done     <= 1'b1;
                    hit_pulse    <= 1'b1;
                    hit_in_range <= 1'b1;
                    hit_type     <= atk_q;
                end
                if (launch_en) begin
                    phase_q  <= launch_load.phase;
                    count_q  <= launch_load.count;
                    atk_q    <= (launch_load.phase == PH_IDLE) ? ATK_NONE : launch_type;
                    hit_done <= 1'b0;
`ifdef ATTACK_SEQ_BUFFER_EN
                    buf_q    <= ATK_NONE;
`endif
                end else if (phase_end) begin
                    phase_q <= adv_load.phase;
                    count_q <= adv_load.count;
                    if (adv_load.phase == PH_IDLE)
                        atk_q <= ATK_NONE;
                end else if (phase_q != PH_IDLE) begin
                    if (frame_tick)
                        count_q <= count_q - 4'd1;
`ifdef ATTACK_SEQ_BUFFER_EN
                    if (phase_q == PH_RECOVERY)
                        buf_q <= pend_type;
`endif
                end
            end
        end
    end

    assign phase    = phase_q;
    assign atk_type = atk_q;
    assign busy     = (phase_q != PH_IDLE);

endmodule

// File: tb/tb_attack_sequencer.sv
// Directed bench for attack_sequencer; expectations follow the default frame/reach
// values and switch on ATTACK_SEQ_BUFFER_EN for the recovery-buffer scenario.
module tb_attack_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn_light;
    logic       btn_medium;
    logic       btn_heavy;
    logic       stunned;
    logic       facing_right;
    logic [9:0] pos_self;
    logic [9:0] pos_opp;
    logic [1:0] phase;
    logic [1:0] atk_type;
    logic [1:0] hit_type;
    logic       hit_pulse;
    logic       hit_in_range;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int pulse_count = 0;
    int base;

    attack_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .btn_light   (btn_light),
        .btn_medium  (btn_medium),
        .btn_heavy   (btn_heavy),
        .stunned     (stunned),
        .facing_right(facing_right),
        .pos_self    (pos_self),
        .pos_opp     (pos_opp),
        .phase       (phase),
        .atk_type    (atk_type),
        .hit_type    (hit_type),
        .hit_pulse   (hit_pulse),
        .hit_in_range(hit_in_range),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Every cycle with hit_pulse high is one hit event
    always @(negedge clk) begin
        if (hit_pulse) pulse_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame tick cycle followed by one quiet cycle
    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        compared++;
        if (phase !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_phase got=%b want=00", phase); end
        compared++;
        if (atk_type !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_atk got=%b want=00", atk_type); end
        compared++;
        if ({hit_pulse, hit_in_range, hit_type, busy} !== 5'b0) begin
            mismatched++; $display("[TB] FAIL reset_outputs got=%b want=00000", {hit_pulse, hit_in_range, hit_type, busy});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_light();
        pos_self = 10'd100; pos_opp = 10'd130; facing_right = 1'b1;
        base = pulse_count;
        // press together with a frame tick: the tick must not shorten startup
        btn_light = 1'b1; frame_tick = 1'b1;
        step();
        btn_light = 1'b0; frame_tick = 1'b0;
        compared++;
        if (phase !== 2'b01 || atk_type !== 2'b01) begin
            mismatched++; $display("[TB] FAIL light_enter phase=%b atk=%b want 01/01", phase, atk_type);
        end
        step();
        tick();
        compared++;
        if (phase !== 2'b01) begin mismatched++; $display("[TB] FAIL light_startup1 got=%b want=01", phase); end
        tick();
        compared++;
        if (phase !== 2'b10) begin mismatched++; $display("[TB] FAIL light_active got=%b want=10", phase); end
        compared++;
        if (hit_pulse !== 1'b1 || hit_type !== 2'b01 || hit_in_range !== 1'b1) begin
            mismatched++; $display("[TB] FAIL light_hit pulse=%b type=%b range=%b want 1/01/1", hit_pulse, hit_type, hit_in_range);
        end
        step();
        compared++;
        if (hit_pulse !== 1'b0 || hit_type !== 2'b00) begin
            mismatched++; $display("[TB] FAIL light_hit_single pulse=%b type=%b want 0/00", hit_pulse, hit_type);
        end
        tick();
        compared++;
        if (phase !== 2'b10) begin mismatched++; $display("[TB] FAIL light_active2 got=%b want=10", phase); end
        tick();
        compared++;
        if (phase !== 2'b11) begin mismatched++; $display("[TB] FAIL light_recovery got=%b want=11", phase); end
        tick_n(3);
        compared++;
        if (phase !== 2'b11 || busy !== 1'b1) begin
            mismatched++; $display("[TB] FAIL light_recovery_end phase=%b busy=%b want 11/1", phase, busy);
        end
        tick();
        compared++;
        if (phase !== 2'b00 || atk_type !== 2'b00 || busy !== 1'b0) begin
            mismatched++; $display("[TB] FAIL light_idle phase=%b atk=%b busy=%b want 00/00/0", phase, atk_type, busy);
        end
        compared++;
        if (pulse_count - base !== 1) begin mismatched++; $display("[TB] FAIL light_pulses got=%0d want=1", pulse_count - base); end
    endtask

    task automatic test_heavy(input logic [9:0] self_x, input logic [9:0] opp_x,
                              input logic face_r, input int want_pulses);
        pos_self = self_x; pos_opp = opp_x; facing_right = face_r;
        base = pulse_count;
        btn_heavy = 1'b1;
        step();
        btn_heavy = 1'b0;
        compared++;
        if (phase !== 2'b01 || atk_type !== 2'b11) begin
            mismatched++; $display("[TB] FAIL heavy_enter phase=%b atk=%b want 01/11", phase, atk_type);
        end
        tick_n(7);
        compared++;
        if (phase !== 2'b01) begin mismatched++; $display("[TB] FAIL heavy_startup7 got=%b want=01", phase); end
        tick();
        compared++;
        if (phase !== 2'b10) begin mismatched++; $display("[TB] FAIL heavy_active got=%b want=10", phase); end
        compared++;
        if (hit_pulse !== (want_pulses == 1) || hit_type !== ((want_pulses == 1) ? 2'b11 : 2'b00)) begin
            mismatched++; $display("[TB] FAIL heavy_hit pulse=%b type=%b want_pulses=%0d", hit_pulse, hit_type, want_pulses);
        end
        tick_n(3);
        compared++;
        if (phase !== 2'b10) begin mismatched++; $display("[TB] FAIL heavy_active4 got=%b want=10", phase); end
        tick();
        compared++;
        if (phase !== 2'b11) begin mismatched++; $display("[TB] FAIL heavy_recovery got=%b want=11", phase); end
        tick_n(13);
        compared++;
        if (phase !== 2'b11) begin mismatched++; $display("[TB] FAIL heavy_recovery14 got=%b want=11", phase); end
        tick();
        compared++;
        if (phase !== 2'b00 || busy !== 1'b0) begin
            mismatched++; $display("[TB] FAIL heavy_idle phase=%b busy=%b want 00/0", phase, busy);
        end
        compared++;
        if (pulse_count - base !== want_pulses) begin
            mismatched++; $display("[TB] FAIL heavy_pulses got=%0d want=%0d", pulse_count - base, want_pulses);
        end
    endtask

    task automatic test_back_to_back();
        pos_self = 10'd100; pos_opp = 10'd130; facing_right = 1'b1;
        base = pulse_count;
        btn_light = 1'b1; btn_medium = 1'b1; btn_heavy = 1'b1;
        step();
        btn_light = 1'b0; btn_medium = 1'b0; btn_heavy = 1'b0;
        compared++;
        if (atk_type !== 2'b11 || phase !== 2'b01) begin
            mismatched++; $display("[TB] FAIL simul_priority atk=%b phase=%b want 11/01", atk_type, phase);
        end
        tick_n(8);
        btn_light = 1'b1; step(); btn_light = 1'b0; step();
        btn_medium = 1'b1; step(); btn_medium = 1'b0; step();
        compared++;
        if (phase !== 2'b10 || atk_type !== 2'b11) begin
            mismatched++; $display("[TB] FAIL repress_active phase=%b atk=%b want 10/11", phase, atk_type);
        end
        tick_n(18);
        compared++;
        if (phase !== 2'b00) begin mismatched++; $display("[TB] FAIL repress_idle got=%b want=00", phase); end
        compared++;
        if (pulse_count - base !== 1) begin mismatched++; $display("[TB] FAIL repress_pulses got=%0d want=1", pulse_count - base); end
    endtask

    task automatic test_stunned();
        pos_self = 10'd100; pos_opp = 10'd300; facing_right = 1'b1;
        base = pulse_count;
        btn_medium = 1'b1; step(); btn_medium = 1'b0;
        tick_n(5);
        compared++;
        if (phase !== 2'b10 || atk_type !== 2'b10) begin
            mismatched++; $display("[TB] FAIL stun_active phase=%b atk=%b want 10/10", phase, atk_type);
        end
        stunned = 1'b1; pos_opp = 10'd120;
        step();
        compared++;
        if (phase !== 2'b00 || atk_type !== 2'b00 || hit_pulse !== 1'b0) begin
            mismatched++; $display("[TB] FAIL stun_idle phase=%b atk=%b pulse=%b want 00/00/0", phase, atk_type, hit_pulse);
        end
        stunned = 1'b0;
        step();
        step();
        compared++;
        if (pulse_count - base !== 0) begin mismatched++; $display("[TB] FAIL stun_pulses got=%0d want=0", pulse_count - base); end
        btn_light = 1'b1; step(); btn_light = 1'b0;
        compared++;
        if (phase !== 2'b01 || atk_type !== 2'b01) begin
            mismatched++; $display("[TB] FAIL stun_repress phase=%b atk=%b want 01/01", phase, atk_type);
        end
        do_reset();
    endtask

    task automatic test_reset_on_hit();
        pos_self = 10'd100; pos_opp = 10'd130; facing_right = 1'b1;
        base = pulse_count;
        btn_light = 1'b1; step(); btn_light = 1'b0;
        tick();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        compared++;
        if (phase !== 2'b10) begin mismatched++; $display("[TB] FAIL rst_hit_active got=%b want=10", phase); end
        reset = 1'b1;
        step();
        compared++;
        if ({phase, atk_type, hit_type, hit_pulse, hit_in_range, busy} !== 9'b0) begin
            mismatched++; $display("[TB] FAIL rst_hit_outputs got=%b want=0", {phase, atk_type, hit_type, hit_pulse, hit_in_range, busy});
        end
        reset = 1'b0;
        step();
        step();
        compared++;
        if (pulse_count - base !== 0) begin mismatched++; $display("[TB] FAIL rst_hit_pulses got=%0d want=0", pulse_count - base); end
    endtask

    task automatic test_buffer();
        logic [1:0] want_phase;
        logic [1:0] want_atk;
`ifdef ATTACK_SEQ_BUFFER_EN
        want_phase = 2'b01; want_atk = 2'b10;
`else
        want_phase = 2'b00; want_atk = 2'b00;
`endif
        pos_self = 10'd100; pos_opp = 10'd300; facing_right = 1'b1;
        btn_light = 1'b1; step(); btn_light = 1'b0;
        tick_n(4);
        compared++;
        if (phase !== 2'b11) begin mismatched++; $display("[TB] FAIL buf_recovery got=%b want=11", phase); end
        btn_medium = 1'b1; step(); btn_medium = 1'b0;
        tick_n(3);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        compared++;
        if (phase !== want_phase || atk_type !== want_atk) begin
            mismatched++; $display("[TB] FAIL buf_end phase=%b atk=%b want %b/%b", phase, atk_type, want_phase, want_atk);
        end
        step();
        step();
        compared++;
        if (phase !== want_phase || atk_type !== want_atk) begin
            mismatched++; $display("[TB] FAIL buf_after phase=%b atk=%b want %b/%b", phase, atk_type, want_phase, want_atk);
        end
        do_reset();
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; stunned = 1'b0;
        btn_light = 1'b0; btn_medium = 1'b0; btn_heavy = 1'b0;
        facing_right = 1'b1; pos_self = 10'd0; pos_opp = 10'd0;
        step();
        test_reset();
        test_light();
        test_heavy(10'd100, 10'd173, 1'b1, 0);
        test_heavy(10'd200, 10'd128, 1'b0, 1);
        test_back_to_back();
        test_stunned();
        test_reset_on_hit();
        test_buffer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/attack_sequencer.md
# attack_sequencer

Per-player attack state machine that turns debounced attack buttons into timed startup/active/recovery phases on the 60 Hz frame tick. During the active window it performs the reach check against the opponent. It emits exactly one single-cycle hit event per attack. It sits directly upstream of the health management block: `hit_pulse`, `hit_in_range` and `hit_type` are the hit-range and attack-state inputs there. `hit_type` is non-zero for exactly one clock per landed hit, so damage is applied once.

## Interface
- `LIGHT_FRAMES`, 12'h224: startup/active/recovery frame counts, 4 bits each, MSB nibble = startup.
- `MEDIUM_FRAMES`, 12'h438: same packing.
- `HEAVY_FRAMES`, 12'h84E: same packing.
- `LIGHT_REACH`, 40: reach in pixels.
- `MEDIUM_REACH`, 56: reach in pixels.
- `HEAVY_REACH`, 72: reach in pixels.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `frame_tick` in 1: one-clk pulse per video frame.
- `btn_light`, `btn_medium`, `btn_heavy` in 1 each: debounced, clk-synchronous levels.
- `stunned` in 1: level; aborts any attack.
- `facing_right` in 1: 1 = opponent expected at a higher x.
- `pos_self`, `pos_opp` in 10 each: unsigned x positions in pixels.
- `phase` out 2: 00 IDLE, 01 STARTUP, 10 ACTIVE, 11 RECOVERY.
- `atk_type` out 2: type of the current attack (01 light, 10 medium, 11 heavy), 00 in IDLE.
- `hit_type` out 2: equals `atk_type` only in the `hit_pulse` cycle, else 00.
- `hit_pulse` out 1: single-cycle hit event.
- `hit_in_range` out 1: registered copy of the reach check, asserted together with `hit_pulse`.
- `busy` out 1: `phase != IDLE`.

## Operation
- **Button edges**
  - Rising edges are detected on every clk using internal previous-value registers.
  - Simultaneous edges resolve by priority: heavy > medium > light.
- **IDLE**
  - An edge, with `stunned` low, moves the FSM to STARTUP.
  - It latches `atk_type` and loads the frame counter with that type's startup count.
- **Phase counting**
  - The counter decrements only on `frame_tick`.
  - When the counter is 1 and `frame_tick` is high, the FSM advances STARTUP→ACTIVE→RECOVERY→IDLE, reloading the counter with the next field.
  - A zero-length field is skipped the same cycle: the next field is loaded, or the FSM goes to IDLE.
- **Edges outside IDLE** are ignored, unless the buffer feature is compiled in.
- **Reach check**, 11-bit unsigned difference, no wrap:
  - `facing_right`: hit when `pos_opp >= pos_self` and `pos_opp - pos_self <= reach(atk_type)`.
  - Otherwise: hit when `pos_self >= pos_opp` and `pos_self - pos_opp <= reach`.
  - Equal positions count as in range.
- **Hit generation**
  - In ACTIVE, the first clk where the reach check passes and `hit_done == 0` sets `hit_done`.
  - The next clk asserts `hit_pulse`, `hit_in_range` and `hit_type` for one cycle.
  - This pulse is issued even if the FSM left ACTIVE in that same cycle.
  - `hit_done` clears on entry to STARTUP.
- **`stunned` high** in any state:
  - Next state is IDLE, `atk_type` goes to 00, `hit_done` and the buffer clear.
  - An already-scheduled `hit_pulse` is suppressed.
- **Reset**
  - Every output is 0 and the FSM is IDLE; the counter, `hit_done`, the buffer and the previous-button registers are 0.
  - Reset mid-attack takes effect on the next edge with no hit.

## Timing
- Button edge at clk N → `phase` = STARTUP at N+1.
- Attack length is exactly S+A+R frame ticks after entry.
- Reach pass at clk M in ACTIVE → `hit_pulse` at M+1; at most one pulse per attack.
- `frame_tick` and a button edge in the same IDLE cycle: the edge is taken, and the tick is not counted against the new startup.

## Configuration
- `ATTACK_SEQ_BUFFER_EN` defined:
  - A button edge during RECOVERY is stored in a 2-bit buffer; it is overwritten only by a higher-priority type.
  - When RECOVERY ends, the FSM goes directly to STARTUP with the buffered type instead of IDLE, with no idle cycle.
  - The buffer is cleared by reset, `stunned`, or launch.
- Undefined: presses in any non-IDLE phase are dropped and no buffer register exists.

## Structure
- Shared package `fighter_pkg`:
  - phase encodings and attack type encodings (01/10/11, shared with health management);
  - frame-field packing helpers;
  - default reach constants.
- One sub-module, `attack_range_check`: a combinational reach comparator taking `pos_self`, `pos_opp`, `facing_right` and `atk_type`, and returning `in_range`.
- The FSM, counter, edge detect and buffer live in the top module.

## Test plan
- Light press, `pos_self`=100, `pos_opp`=130, facing right → STARTUP 2 ticks, ACTIVE 2 ticks, one `hit_pulse` with `hit_type`=01, RECOVERY 4 ticks, then IDLE.
- Heavy press, opponent at distance 73 → full heavy cycle of 8/4/14 ticks, `hit_pulse` never asserted; distance 72 → exactly one pulse with `hit_type`=11.
- Light, medium and heavy edges in the same cycle → `atk_type`=11; repeated presses during ACTIVE produce no second pulse and no restart.
- `stunned` asserted in the second frame of medium ACTIVE, before the opponent enters range → IDLE next clk, no pulse, a new press afterwards accepted normally.
- Reset asserted the same cycle a hit is detected → `hit_pulse` stays 0 and all outputs read 0 next clk.
- With `ATTACK_SEQ_BUFFER_EN`: medium press during light RECOVERY → STARTUP with `atk_type`=10 the cycle RECOVERY ends; without the macro → IDLE, and the press is lost.
